// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction input stage.
package snake_pkg;

    // System clock frequency in Hz.
    localparam int unsigned CLK_HZ = 25_200_000;

    // Movement direction encoding. Opposite directions differ only in bit 1.
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    // Returns the direction that would be a 180 degree reversal of d.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stability counter and a
// registered single-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 252000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // Counter restarts whenever the sample agrees with the debounced level;
    // after enough consecutive disagreeing samples the level flips.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    // Synchroniser, debounce state and registered press pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction input stage: four debounced buttons feed a small turn
// queue; one queued turn is applied to mov_dir per movement tick.
// Optional build macro SNAKE_DIR_DBG_EN adds a saturating drop counter
// on the dbg bus; without it dbg is constant zero.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 252000,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic       clk_25_2,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       move_tick,
    output logic [1:0] mov_dir,
    output logic [2:0] q_count,
    output logic [7:0] dbg
);

    localparam logic [2:0] DEPTH    = 3'(QUEUE_DEPTH);
    localparam logic [1:0] LAST_PTR = 2'(QUEUE_DEPTH - 1);

    // Pointer advance with wrap at the configured depth.
    function automatic logic [1:0] inc_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    logic [3:0] rise;

    // Storage is always four entries so a 2-bit pointer indexes it cleanly;
    // only the first QUEUE_DEPTH entries are ever written.
    dir_t       fifo_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q,  count_d;
    dir_t       mov_dir_q, mov_dir_d;

    logic       req_valid;
    dir_t       req_dir;
    logic [1:0] tail_ptr;
    dir_t       ref_dir;
    logic       accept;
    logic       full, empty;
    logic       push, pop;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i (clk_25_2),
            .rst_ni(rst_n),
            .btn_i (btn[i]),
            .rise_o(rise[i])
        );
    end

    // Pick one request per cycle: right > down > left > up.
    always_comb begin
        req_valid = |rise;
        req_dir   = DIR_RIGHT;
        if (rise[0])      req_dir = DIR_RIGHT;
        else if (rise[1]) req_dir = DIR_DOWN;
        else if (rise[2]) req_dir = DIR_LEFT;
        else if (rise[3]) req_dir = DIR_UP;
    end

    // Accept a turn only if it changes heading without reversing, judged
    // against the last queued turn (or the live direction when empty).
    always_comb begin
        full     = (count_q == DEPTH);
        empty    = (count_q == 3'd0);
        tail_ptr = (wr_ptr_q == 2'd0) ? LAST_PTR : wr_ptr_q - 2'd1;
        ref_dir  = empty ? mov_dir_q : fifo_q[tail_ptr];
        accept   = req_valid && (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
        pop      = move_tick && !empty;
        push     = accept && (!full || pop);
    end

    // Queue pointers, occupancy and the applied direction.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mov_dir_d = mov_dir_q;
        if (push) wr_ptr_d = inc_ptr(wr_ptr_q);
        if (pop) begin
            rd_ptr_d  = inc_ptr(rd_ptr_q);
            mov_dir_d = fifo_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue and direction registers.
    always_ff @(posedge clk_25_2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= DIR_RIGHT;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            mov_dir_q <= DIR_RIGHT;
        end else begin
            if (push) fifo_q[wr_ptr_q] <= req_dir;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mov_dir_q <= mov_dir_d;
        end
    end

    assign mov_dir = mov_dir_q;
    assign q_count = count_q;

`ifdef SNAKE_DIR_DBG_EN
    logic [5:0] drop_cnt_q, drop_cnt_d;
    logic [2:0] n_req, n_drop;
    logic [6:0] drop_sum;

    // Every press event that does not land in the queue counts as a drop,
    // including events that lost the priority pick.
    always_comb begin
        n_req      = 3'(rise[0]) + 3'(rise[1]) + 3'(rise[2]) + 3'(rise[3]);
        n_drop     = n_req - {2'b00, push};
        drop_sum   = {1'b0, drop_cnt_q} + {4'b0000, n_drop};
        drop_cnt_d = (drop_sum > 7'd63) ? 6'd63 : drop_sum[5:0];
    end

    // Saturating drop counter.
    always_ff @(posedge clk_25_2 or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= 6'd0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign dbg = {count_q[1:0], drop_cnt_q};
`else
    assign dbg = 8'h00;
`endif

endmodule
